// File: rtl/rose_stim_gen.sv
// Stimulus generator and scorer for a rose checker; ROSE_STIM_FAILCHK_EN
// additionally requires fail_in to be the complement of match_in.
module rose_stim_gen (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] pattern,
  input  logic [15:0] en_pattern,
  input  logic [3:0]  len,
  output logic        signal_out,
  output logic        en_out,
  input  logic        match_in,
  input  logic        fail_in,
  output logic        busy,
  output logic        done,
  output logic [7:0]  pass_cnt,
  output logic [7:0]  err_cnt,
  output logic        err_flag
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t      state;
  logic [15:0] pat_q;
  logic [15:0] en_q;
  logic [3:0]  len_q;
  logic [3:0]  k;
  logic [3:0]  k_nx;
  logic [3:0]  km1;
  logic        pend_v;
  logic        pend_exp;
  logic        agree;

  assign k_nx = k + 4'd1;
  assign km1  = k - 4'd1;

`ifdef ROSE_STIM_FAILCHK_EN
  assign agree = (match_in == pend_exp) &&
                 (fail_in != match_in);
`else
  logic fail_unused;
  assign fail_unused = fail_in;
  assign agree = (match_in == pend_exp);
`endif

  // pend_* holds the prediction for the bit driven last cycle,
  // scored one cycle later to absorb the checker latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pat_q      <= '0;
      en_q       <= '0;
      len_q      <= '0;
      k          <= '0;
      pend_v     <= 1'b0;
      pend_exp   <= 1'b0;
      signal_out <= 1'b0;
      en_out     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass_cnt   <= '0;
      err_cnt    <= '0;
      err_flag   <= 1'b0;
    end else begin
      if (pend_v) begin
        if (agree) begin
          if (pass_cnt != 8'hFF)
            pass_cnt <= pass_cnt + 8'd1;
        end else begin
          if (err_cnt != 8'hFF)
            err_cnt <= err_cnt + 8'd1;
          err_flag <= 1'b1;
        end
      end
      unique case (state)
        IDLE: begin
          if (start) begin
            pat_q      <= pattern;
            en_q       <= en_pattern;
            len_q      <= len;
            k          <= '0;
            pass_cnt   <= '0;
            err_cnt    <= '0;
            err_flag   <= 1'b0;
            pend_v     <= 1'b0;
            signal_out <= pattern[0];
            en_out     <= en_pattern[0];
            busy       <= 1'b1;
            state      <= RUN;
          end
        end
        RUN: begin
          pend_v   <= (k != 4'd0);
          pend_exp <= ~pat_q[km1] & pat_q[k] &
                      en_q[km1];
          if (k == len_q) begin
            signal_out <= 1'b0;
            en_out     <= 1'b0;
            state      <= DRAIN;
          end else begin
            k          <= k_nx;
            signal_out <= pat_q[k_nx];
            en_out     <= en_q[k_nx];
          end
        end
        DRAIN: begin
          pend_v <= 1'b0;
          done   <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rose_stim_gen.sv
// Randomized bench for rose_stim_gen with a behavioural rose checker
// and a scoring model derived from the rising-edge prediction rule.
module tb_rose_stim_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] pattern = '0;
  logic [15:0] en_pattern = '0;
  logic [3:0]  len = '0;
  logic        signal_out;
  logic        en_out;
  logic        match_in;
  logic        fail_in;
  logic        busy;
  logic        done;
  logic [7:0]  pass_cnt;
  logic [7:0]  err_cnt;
  logic        err_flag;

  int n_tests = 0;
  int n_fail = 0;

  rose_stim_gen dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .pattern    (pattern),
    .en_pattern (en_pattern),
    .len        (len),
    .signal_out (signal_out),
    .en_out     (en_out),
    .match_in   (match_in),
    .fail_in    (fail_in),
    .busy       (busy),
    .done       (done),
    .pass_cnt   (pass_cnt),
    .err_cnt    (err_cnt),
    .err_flag   (err_flag)
  );

  always #5 clk = ~clk;

  // rose checker model; flip[k] corrupts the answer for bit k
  logic        prev_s = 1'b0;
  logic        prev_e = 1'b0;
  logic        m_q = 1'b0;
  logic [4:0]  idx = '0;
  logic [15:0] flip = '0;
  bit          force_m1 = 1'b0;
  bit          force_f0 = 1'b0;

  always @(posedge clk) begin
    prev_s <= signal_out;
    prev_e <= en_out;
    m_q    <= (~prev_s & signal_out & prev_e) ^
              ((idx < 5'd16) ? flip[idx[3:0]] : 1'b0);
    idx    <= busy ? idx + 5'd1 : 5'd0;
  end

  assign match_in = force_m1 ? 1'b1 : m_q;
  assign fail_in  = force_f0 ? 1'b0 : ~match_in;

  function automatic void model(
    input  logic [15:0] p,
    input  logic [15:0] e,
    input  logic [3:0]  l,
    input  logic [15:0] fl,
    input  bit          fm1,
    input  bit          ff0,
    output int          pc,
    output int          ec
  );
    pc = 0;
    ec = 0;
    for (int b = 1; b <= int'(l); b++) begin
      bit ex;
      bit m;
      bit ok;
      ex = !p[b-1] && p[b] && e[b-1];
      m  = fm1 ? 1'b1 : (ex ^ fl[b]);
      ok = (m == ex);
`ifdef ROSE_STIM_FAILCHK_EN
      ok = ok && ((ff0 ? 1'b0 : !m) == !m);
`else
      if (ff0) ok = ok;
`endif
      if (ok) pc++;
      else ec++;
    end
  endfunction

  function automatic logic [17:0] bits_of(
    input logic [15:0] p,
    input logic [3:0]  l
  );
    int n;
    n = int'(l) + 1;
    return {2'b00, p} & ((18'd1 << n) - 18'd1);
  endfunction

  task automatic do_run(
    input  logic [15:0] p,
    input  logic [15:0] e,
    input  logic [3:0]  l,
    output logic [17:0] sig,
    output logic [17:0] en,
    output int          done_cyc,
    output int          dones,
    output logic [7:0]  pc,
    output logic [7:0]  ec,
    output logic        fl_o,
    output logic        stable
  );
    sig = '0;
    en = '0;
    done_cyc = -1;
    dones = 0;
    pc = '0;
    ec = '0;
    fl_o = 1'b0;
    stable = 1'b0;
    @(negedge clk);
    pattern = p;
    en_pattern = e;
    len = l;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pattern = 16'($urandom);
    en_pattern = 16'($urandom);
    len = 4'($urandom);
    for (int c = 0; c < 40; c++) begin
      if (c < 18) begin
        sig[c] = signal_out;
        en[c] = en_out;
      end
      if (done) begin
        dones++;
        if (done_cyc < 0) begin
          done_cyc = c;
          pc = pass_cnt;
          ec = err_cnt;
          fl_o = err_flag;
        end
      end
      if (done_cyc >= 0 && c >= done_cyc + 2) begin
        stable = !busy && !done &&
                 pass_cnt == pc && err_cnt == ec &&
                 err_flag == fl_o;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_tests++;
    if ({signal_out, en_out, busy, done, pass_cnt,
         err_cnt, err_flag} !== 21'd0) begin
      n_fail++;
      $display("FAIL reset_hold: got %0h want 0",
        {signal_out, en_out, busy, done, pass_cnt,
         err_cnt, err_flag});
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({signal_out, en_out, busy, done, pass_cnt,
         err_cnt, err_flag} !== 21'd0) begin
      n_fail++;
      $display("FAIL reset_release: got %0h want 0",
        {signal_out, en_out, busy, done, pass_cnt,
         err_cnt, err_flag});
    end
  endtask

  task automatic test_basic();
    logic [17:0] s, e;
    int dc, nd;
    logic [7:0] pc, ec;
    logic fl, st;
    do_run(16'h000A, 16'hFFFF, 4'd3, s, e, dc, nd,
           pc, ec, fl, st);
    n_tests++;
    if (s !== 18'h0000A) begin
      n_fail++;
      $display("FAIL basic_sig: got %0h want a", s);
    end
    n_tests++;
    if (e !== 18'h0000F) begin
      n_fail++;
      $display("FAIL basic_en: got %0h want f", e);
    end
    n_tests++;
    if ({pc, ec, fl} !== {8'd3, 8'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL basic_cnt: got %0d/%0d/%0d want 3/0/0",
        pc, ec, fl);
    end
    n_tests++;
    if (dc !== 5 || nd !== 1 || st !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_done: got cyc %0d n %0d st %0d want 5 1 1",
        dc, nd, st);
    end
  endtask

  task automatic test_forced_match();
    logic [17:0] s, e;
    int dc, nd;
    logic [7:0] pc, ec;
    logic fl, st;
    force_m1 = 1'b1;
    do_run(16'h0002, 16'h0000, 4'd1, s, e, dc, nd,
           pc, ec, fl, st);
    force_m1 = 1'b0;
    n_tests++;
    if ({pc, ec, fl} !== {8'd0, 8'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL forced_match: got %0d/%0d/%0d want 0/1/1",
        pc, ec, fl);
    end
    n_tests++;
    if (st !== 1'b1) begin
      n_fail++;
      $display("FAIL forced_stable: got %0d want 1", st);
    end
  endtask

  task automatic test_len0();
    logic [17:0] s, e;
    int dc, nd;
    logic [7:0] pc, ec;
    logic fl, st;
    logic [15:0] p;
    p = 16'($urandom) | 16'h0001;
    do_run(p, 16'hFFFF, 4'd0, s, e, dc, nd,
           pc, ec, fl, st);
    n_tests++;
    if (s !== 18'd1 || e !== 18'd1) begin
      n_fail++;
      $display("FAIL len0_sig: got %0h/%0h want 1/1", s, e);
    end
    n_tests++;
    if ({pc, ec, fl} !== 17'd0 || nd !== 1 || dc !== 2) begin
      n_fail++;
      $display("FAIL len0_done: got %0d/%0d n %0d cyc %0d want 0/0 1 2",
        pc, ec, nd, dc);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      logic [15:0] p, e, fl_m;
      logic [3:0] l;
      logic [17:0] s, en_o;
      int dc, nd, mp, me;
      logic [7:0] pc, ec;
      logic fl, st;
      p = 16'($urandom);
      e = 16'($urandom) | 16'($urandom);
      l = 4'($urandom);
      fl_m = (i % 2 == 0) ? 16'h0 :
             16'($urandom) & 16'($urandom);
      flip = fl_m;
      do_run(p, e, l, s, en_o, dc, nd,
             pc, ec, fl, st);
      flip = '0;
      model(p, e, l, fl_m, 1'b0, 1'b0, mp, me);
      n_tests++;
      if (s !== bits_of(p, l) || en_o !== bits_of(e, l)) begin
        n_fail++;
        $display("FAIL rand_stream[%0d]: got %0h/%0h want %0h/%0h",
          i, s, en_o, bits_of(p, l), bits_of(e, l));
      end
      n_tests++;
      if (int'(pc) !== mp || int'(ec) !== me ||
          fl !== (me != 0)) begin
        n_fail++;
        $display("FAIL rand_cnt[%0d]: got %0d/%0d/%0d want %0d/%0d",
          i, pc, ec, fl, mp, me);
      end
      n_tests++;
      if (dc !== int'(l) + 2 || nd !== 1 || st !== 1'b1) begin
        n_fail++;
        $display("FAIL rand_done[%0d]: got cyc %0d n %0d st %0d want %0d 1 1",
          i, dc, nd, st, int'(l) + 2);
      end
    end
  endtask

  task automatic test_reset_midrun();
    logic [17:0] s, e;
    int dc, nd, mp, me, busy_cnt;
    logic [7:0] pc, ec;
    logic fl, st;
    logic [15:0] p;
    @(negedge clk);
    pattern = 16'($urandom) | 16'h0020;
    en_pattern = 16'hFFFF;
    len = 4'd15;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    n_tests++;
    if (signal_out !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_pre: got sig %0d busy %0d want 1 1",
        signal_out, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({signal_out, en_out, busy, done} !== 4'd0) begin
      n_fail++;
      $display("FAIL abort_async: got %0b want 0000",
        {signal_out, en_out, busy, done});
    end
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    busy_cnt = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) nd++;
      if (busy) busy_cnt++;
    end
    n_tests++;
    if (nd !== 0 || busy_cnt !== 0) begin
      n_fail++;
      $display("FAIL abort_nodone: got done %0d busy %0d want 0 0",
        nd, busy_cnt);
    end
    p = 16'($urandom);
    do_run(p, 16'hFFFF, 4'd9, s, e, dc, nd,
           pc, ec, fl, st);
    model(p, 16'hFFFF, 4'd9, 16'h0, 1'b0, 1'b0, mp, me);
    n_tests++;
    if (s !== bits_of(p, 4'd9) || int'(pc) !== mp ||
        int'(ec) !== me || dc !== 11 || nd !== 1) begin
      n_fail++;
      $display("FAIL abort_rerun: got %0h %0d/%0d cyc %0d want %0h %0d/%0d 11",
        s, pc, ec, dc, bits_of(p, 4'd9), mp, me);
    end
  endtask

  task automatic test_start_held();
    int nd, nr, gap, first;
    logic pb;
    logic [3:0] l;
    l = 4'd15;
    nd = 0;
    nr = 0;
    first = -1;
    gap = -1;
    pb = 1'b0;
    @(negedge clk);
    pattern = 16'($urandom);
    en_pattern = 16'($urandom);
    len = l;
    start = 1'b1;
    for (int c = 0; c < 45; c++) begin
      @(negedge clk);
      if (c == 36) start = 1'b0;
      if (busy && !pb) begin
        nr++;
        if (first < 0) first = c;
        else if (gap < 0) gap = c - first;
      end
      if (done) nd++;
      pb = busy;
    end
    n_tests++;
    if (nd !== 2 || nr !== 2) begin
      n_fail++;
      $display("FAIL held_runs: got done %0d starts %0d want 2 2",
        nd, nr);
    end
    n_tests++;
    if (gap !== int'(l) + 4) begin
      n_fail++;
      $display("FAIL held_gap: got %0d want %0d",
        gap, int'(l) + 4);
    end
  endtask

  task automatic test_failchk();
    logic [17:0] s, e;
    int dc, nd, mp, me, want;
    logic [7:0] pc, ec;
    logic fl, st;
`ifdef ROSE_STIM_FAILCHK_EN
    want = 1;
`else
    want = 0;
`endif
    force_f0 = 1'b1;
    do_run(16'h0005, 16'hFFFF, 4'd2, s, e, dc, nd,
           pc, ec, fl, st);
    force_f0 = 1'b0;
    model(16'h0005, 16'hFFFF, 4'd2, 16'h0, 1'b0, 1'b1,
          mp, me);
    n_tests++;
    if (int'(ec) !== want || int'(pc) !== 2 - want ||
        me !== want || mp !== 2 - want) begin
      n_fail++;
      $display("FAIL failchk: got %0d/%0d want %0d/%0d",
        pc, ec, 2 - want, want);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_forced_match();
    test_len0();
    test_random();
    test_reset_midrun();
    test_start_held();
    test_failchk();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rose_stim_gen.md
ROSE_STIM_GEN -- requirements
Module: rose_stim_gen

Interface
REQ-001 Parameter: none; all widths fixed as listed below.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  run request; a one-cycle pulse is sufficient.
REQ-005 pattern  input  16  signal bit sequence, transmitted LSB first.
REQ-006 en_pattern  input  16  enable bit sequence, bit k paired with pattern[k].
REQ-007 len  input  4  run length minus one; a run transmits len+1 bits (1..16).
REQ-008 signal_out  output  1  registered stimulus to the rose checker signal_in.
REQ-009 en_out  output  1  registered stimulus to the rose checker en.
REQ-010 match_in  input  1  rose checker match result.
REQ-011 fail_in  input  1  rose checker fail result.
REQ-012 busy  output  1  high from the cycle after start is accepted until DONE is left.
REQ-013 done  output  1  one-cycle pulse at run end.
REQ-014 pass_cnt  output  8  compares that agreed with prediction in the current run.
REQ-015 err_cnt  output  8  compares that disagreed with prediction in the current run.
REQ-016 err_flag  output  1  high when err_cnt is nonzero; holds until the next accepted start.

Function
REQ-017 FSM states: IDLE, RUN, DRAIN, DONE; reset state IDLE.
REQ-018 IDLE: start=1 latches pattern, en_pattern and len, clears pass_cnt/err_cnt/err_flag, sets bit index k=0, goes to RUN.
REQ-019 start while not in IDLE is ignored; latched values do not change during a run.
REQ-020 RUN: signal_out=pattern[k], en_out=en_pattern[k] for cycle k; k increments each cycle; after k=len goes to DRAIN.
REQ-021 DRAIN: one cycle; signal_out and en_out return to 0; then DONE.
REQ-022 DONE: done=1 for exactly one cycle, busy drops, then IDLE; a start in DONE is ignored.
REQ-023 Prediction for bit k (k>=1): exp = ~pattern[k-1] & pattern[k] & en_pattern[k-1].
REQ-024 exp for bit k is compared to match_in in the cycle after bit k is driven (checker two-stage latency); bit 0 is never compared.
REQ-025 A run makes exactly len compares; len=0 makes none, pass_cnt=err_cnt=0 at done.
REQ-026 Agreement increments pass_cnt, disagreement increments err_cnt; both saturate at 255, no wrap.
REQ-027 Counters and err_flag are stable from done until the next accepted start.
REQ-028 start asserted together with the done cycle is not accepted; must be re-presented in IDLE.

Reset
REQ-029 rst_n=0 forces IDLE immediately, irrespective of clk, including mid-run.
REQ-030 Reset values: signal_out=0, en_out=0, busy=0, done=0, pass_cnt=0, err_cnt=0, err_flag=0.
REQ-031 Run aborted by reset produces no done pulse; latched inputs are discarded.

Configuration
REQ-032 Macro ROSE_STIM_FAILCHK_EN defined: each compare also checks fail_in == ~match_in; any violation counts as a disagreement even if match_in equals exp.
REQ-033 Macro undefined: fail_in is ignored; only match_in versus exp is scored.

Verification
REQ-034 pattern=16'h000A, en_pattern=16'hFFFF, len=3, correct checker -> bits 0,1,0,1; pass_cnt=3, err_cnt=0, err_flag=0, done after 6 cycles in RUN/DRAIN/DONE.
REQ-035 pattern=16'h0002, en_pattern=16'h0000, len=1, match_in forced 1 -> err_cnt=1, pass_cnt=0, err_flag=1.
REQ-036 len=0, any pattern -> single bit driven, pass_cnt=err_cnt=0, done pulses once.
REQ-037 rst_n pulsed low at RUN bit 5 of a len=15 run -> signal_out/en_out/busy 0 at once, no done, next start runs cleanly.
REQ-038 start held high for 40 cycles with len=15 -> exactly two runs, second start accepted only in IDLE after DONE.
REQ-039 ROSE_STIM_FAILCHK_EN defined, fail_in forced 0 with correct match_in, pattern=16'h0005, len=2 -> err_cnt=1 on the cycle where match_in=0; macro undefined -> err_cnt=0.
